// File: rtl/pipe_flow_pkg.sv
// +---------------------------------------------------------------------------+
// | pipe_flow_pkg: shared types and stage indices for the pipeline flow ctrl  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package pipe_flow_pkg;

  typedef enum logic [0:0] {
    TRK_IDLE = 1'b0,
    TRK_WAIT = 1'b1
  } trk_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

`default_nettype wire

// File: rtl/miss_tracker.sv
// +---------------------------------------------------------------------------+
// | miss_tracker: IDLE/WAIT cache-miss FSM, stall asserted in the miss cycle  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module miss_tracker
  import pipe_flow_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_hit,
  input  logic i_ready,
  output logic o_miss
);

  trk_state_e r_state;
  trk_state_e w_state_nxt;
  logic       w_new_miss;

  assign w_new_miss = i_req & ~i_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= TRK_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_miss      = 1'b0;
    case (r_state)
      TRK_IDLE: begin
        if (w_new_miss) begin
          w_state_nxt = TRK_WAIT;
          o_miss      = 1'b1;
        end
      end
      TRK_WAIT: begin
        // A fresh miss arriving with the refill keeps the port waiting.
        if (!i_ready || w_new_miss) begin
          o_miss = 1'b1;
        end else begin
          w_state_nxt = TRK_IDLE;
        end
      end
      default: w_state_nxt = TRK_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
// +---------------------------------------------------------------------------+
// | pipe_flow_ctrl: stall/flush/redirect priority resolver for an N-stage     |
// | pipeline; perf counters built with PIPE_FLOW_CTRL_PERF_EN. Revision: 1.0  |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipe_flow_ctrl
  import pipe_flow_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int XLEN   = 32,
  parameter int DSTAGE = STG_MEM
`ifdef PIPE_FLOW_CTRL_PERF_EN
  ,
  parameter int CNTW   = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSTAGE-1:0]      stall_req_i,
  input  logic [NSTAGE-1:0]      redir_req_i,
  input  logic [NSTAGE*XLEN-1:0] redir_pc_i,
  input  logic                   if_req_i,
  input  logic                   icache_hit_i,
  input  logic                   icache_ready_i,
  input  logic                   mem_req_i,
  input  logic                   dcache_hit_i,
  input  logic                   dcache_ready_i,
  input  logic                   core_wait_i,
  output logic [NSTAGE-1:0]      stall_o,
  output logic [NSTAGE-1:0]      flush_o,
  output logic                   redir_valid_o,
  output logic [XLEN-1:0]        redir_pc_o
`ifdef PIPE_FLOW_CTRL_PERF_EN
  ,
  output logic [CNTW-1:0]        perf_stall_cnt_o,
  output logic [CNTW-1:0]        perf_redir_cnt_o
`endif
);

  localparam int IDXW = $clog2(NSTAGE);

  generate
    if (NSTAGE < 3 || NSTAGE > 8 || DSTAGE < 1 || DSTAGE >= NSTAGE) begin : g_bad_cfg
      $error("pipe_flow_ctrl: illegal NSTAGE/DSTAGE");
    end
  endgenerate

  logic              w_imiss;
  logic              w_dmiss;
  logic              w_gstall;
  logic [NSTAGE-1:0] w_sreq_above;
  logic [IDXW-1:0]   w_k;
  logic              w_k_found;
  logic              w_accept;
  wire               w_unused = ^{redir_req_i[0], redir_pc_i[XLEN-1:0]};

  miss_tracker u_itrk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (if_req_i),
    .i_hit   (icache_hit_i),
    .i_ready (icache_ready_i),
    .o_miss  (w_imiss)
  );

  miss_tracker u_dtrk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (mem_req_i),
    .i_hit   (dcache_hit_i),
    .i_ready (dcache_ready_i),
    .o_miss  (w_dmiss)
  );

  assign w_gstall = core_wait_i | w_imiss | w_dmiss;

  // w_sreq_above[i]: some stage at index >= i requests a stall.
  always_comb begin
    w_sreq_above[NSTAGE-1] = stall_req_i[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      w_sreq_above[i] = stall_req_i[i] | w_sreq_above[i+1];
    end
  end

  always_comb begin
    w_k       = '0;
    w_k_found = 1'b0;
    for (int i = 1; i < NSTAGE; i++) begin
      if (redir_req_i[i]) begin
        w_k       = IDXW'(i);
        w_k_found = 1'b1;
      end
    end
    w_accept = w_k_found & ~w_sreq_above[w_k];
  end

  always_comb begin
    stall_o       = '0;
    flush_o       = '0;
    redir_valid_o = 1'b0;
    redir_pc_o    = '0;
    if (!rst_n) begin
      flush_o = '1;
    end else if (w_gstall) begin
      stall_o = '1;
    end else if (w_accept) begin
      redir_valid_o = 1'b1;
      for (int i = 0; i < NSTAGE; i++) begin
        flush_o[i] = (IDXW'(i) <= w_k);
        if (IDXW'(i) == w_k) begin
          redir_pc_o = redir_pc_i[i*XLEN +: XLEN];
        end
      end
    end else begin
      stall_o = w_sreq_above;
      for (int i = 1; i < NSTAGE; i++) begin
        flush_o[i] = stall_req_i[i-1] & ~w_sreq_above[i];
      end
    end
  end

`ifdef PIPE_FLOW_CTRL_PERF_EN
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_redir_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if ((w_gstall || (|stall_req_i)) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (redir_valid_o && (r_redir_cnt != '1)) begin
        r_redir_cnt <= r_redir_cnt + 1'b1;
      end
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_redir_cnt_o = r_redir_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_pipe_flow_ctrl: vector table, corner sequences and random vs. model    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_flow_ctrl;

  localparam int N  = 5;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    stall_req;
  logic [N-1:0]    redir_req;
  logic [N*XL-1:0] redir_pc;
  logic            if_req, ihit, iready;
  logic            mem_req, dhit, dready;
  logic            core_wait;
  logic [N-1:0]    stall_o;
  logic [N-1:0]    flush_o;
  logic            redir_valid;
  logic [XL-1:0]   redir_pc_o;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.NSTAGE(N), .XLEN(XL), .DSTAGE(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_req_i    (stall_req),
    .redir_req_i    (redir_req),
    .redir_pc_i     (redir_pc),
    .if_req_i       (if_req),
    .icache_hit_i   (ihit),
    .icache_ready_i (iready),
    .mem_req_i      (mem_req),
    .dcache_hit_i   (dhit),
    .dcache_ready_i (dready),
    .core_wait_i    (core_wait),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .redir_valid_o  (redir_valid),
    .redir_pc_o     (redir_pc_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] es, input logic [N-1:0] ef,
                            input logic ev, input logic [XL-1:0] epc);
    check({tag, ".stall"}, 64'(stall_o), 64'(es));
    check({tag, ".flush"}, 64'(flush_o), 64'(ef));
    check({tag, ".valid"}, 64'(redir_valid), 64'(ev));
    check({tag, ".pc"},    64'(redir_pc_o), 64'(epc));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each port is "waiting" next cycle exactly when it stalled this cycle.
  logic m_iwait, m_dwait;

  function automatic int highest(input logic [N-1:0] v, input int lo);
    int h = -1;
    for (int i = lo; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic void model(output logic [N-1:0] es, output logic [N-1:0] ef,
                                output logic ev, output logic [XL-1:0] epc,
                                output logic imiss, output logic dmiss);
    int k, j;
    imiss = (if_req && !ihit) || (m_iwait && !iready);
    dmiss = (mem_req && !dhit) || (m_dwait && !dready);
    es = '0; ef = '0; ev = 1'b0; epc = '0;
    if (!rst_n) begin
      ef = '1;
    end else if (core_wait || imiss || dmiss) begin
      es = '1;
    end else begin
      k = highest(redir_req, 1);
      j = highest(stall_req, 0);
      if (k > 0 && j < k) begin
        ev  = 1'b1;
        epc = redir_pc[k*XL +: XL];
        ef  = N'((1 << (k + 1)) - 1);
      end else if (j >= 0) begin
        es = N'((1 << (j + 1)) - 1);
        if (j + 1 < N) ef = N'(1 << (j + 1));
      end
    end
  endfunction

  typedef struct {
    logic [N-1:0]  sreq;
    logic [N-1:0]  rreq;
    logic          cw;
    logic [N-1:0]  es;
    logic [N-1:0]  ef;
    logic          ev;
    logic [XL-1:0] epc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [N-1:0]  es, ef;
    logic          ev, im, dm;
    logic [XL-1:0] epc;

    tbl[0]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 32'h0};
    tbl[1]  = '{5'b00010, 5'b00000, 1'b0, 5'b00011, 5'b00100, 1'b0, 32'h0};
    tbl[2]  = '{5'b00000, 5'b00110, 1'b0, 5'b00000, 5'b00111, 1'b1, 32'h200};
    tbl[3]  = '{5'b01000, 5'b00010, 1'b0, 5'b01111, 5'b10000, 1'b0, 32'h0};
    tbl[4]  = '{5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 32'h0};
    tbl[5]  = '{5'b00001, 5'b00000, 1'b0, 5'b00001, 5'b00010, 1'b0, 32'h0};
    tbl[6]  = '{5'b00000, 5'b10000, 1'b0, 5'b00000, 5'b11111, 1'b1, 32'h400};
    tbl[7]  = '{5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00000, 1'b0, 32'h0};
    tbl[8]  = '{5'b00110, 5'b00100, 1'b0, 5'b00111, 5'b01000, 1'b0, 32'h0};
    tbl[9]  = '{5'b00011, 5'b01000, 1'b0, 5'b00000, 5'b01111, 1'b1, 32'h300};
    tbl[10] = '{5'b00000, 5'b00100, 1'b1, 5'b11111, 5'b00000, 1'b0, 32'h0};
    tbl[11] = '{5'b00010, 5'b00000, 1'b1, 5'b11111, 5'b00000, 1'b0, 32'h0};

    rst_n = 1'b0; stall_req = '0; redir_req = 5'b00110; core_wait = 1'b0;
    if_req = 1'b0; ihit = 1'b0; iready = 1'b0;
    mem_req = 1'b0; dhit = 1'b0; dready = 1'b0;
    redir_pc = {32'h400, 32'h300, 32'h200, 32'h100, 32'h0};
    next_cycle();
    #1;
    check_outs("reset", 5'b00000, 5'b11111, 1'b0, 32'h0);
    rst_n = 1'b1; redir_req = '0;
    next_cycle();

    for (int v = 0; v < 12; v++) begin
      stall_req = tbl[v].sreq; redir_req = tbl[v].rreq; core_wait = tbl[v].cw;
      #1;
      check_outs($sformatf("vec%0d", v), tbl[v].es, tbl[v].ef, tbl[v].ev, tbl[v].epc);
      next_cycle();
    end
    stall_req = '0; redir_req = '0; core_wait = 1'b0;

    // I-side miss: stall cycles 0..3, released in the ready cycle.
    for (int c = 0; c <= 5; c++) begin
      if_req = (c == 0); ihit = 1'b0; iready = (c == 4);
      #1;
      check($sformatf("imiss.stall.c%0d", c), 64'(stall_o), (c < 4) ? 64'h1F : 64'h0);
      check($sformatf("imiss.flush.c%0d", c), 64'(flush_o), 64'h0);
      next_cycle();
    end
    iready = 1'b0;

    // Redirect held through a 3-cycle bus wait, then a single pulse.
    redir_pc[2*XL +: XL] = 32'h80;
    redir_req = 5'b00100;
    for (int c = 0; c < 3; c++) begin
      core_wait = 1'b1;
      #1;
      check($sformatf("cwait.valid.c%0d", c), 64'(redir_valid), 64'h0);
      check($sformatf("cwait.stall.c%0d", c), 64'(stall_o), 64'h1F);
      next_cycle();
    end
    core_wait = 1'b0;
    #1;
    check_outs("cwait.release", 5'b00000, 5'b00111, 1'b1, 32'h80);
    next_cycle();
    redir_req = '0;
    #1;
    check("cwait.single", 64'(redir_valid), 64'h0);
    next_cycle();
    redir_pc[2*XL +: XL] = 32'h200;

    // D-miss in WAIT, reset, then a late ready must not matter.
    mem_req = 1'b1; dhit = 1'b0;
    #1; check("dmiss.c0", 64'(stall_o), 64'h1F);
    next_cycle();
    mem_req = 1'b0;
    #1; check("dmiss.wait", 64'(stall_o), 64'h1F);
    next_cycle();
    rst_n = 1'b0;
    #1; check_outs("dmiss.rst", 5'b00000, 5'b11111, 1'b0, 32'h0);
    next_cycle();
    rst_n = 1'b1; dready = 1'b1;
    #1; check("dmiss.late_ready", 64'(stall_o), 64'h0);
    next_cycle();
    dready = 1'b0;
    #1; check("dmiss.idle", 64'(stall_o), 64'h0);
    next_cycle();

    m_iwait = 1'b0; m_dwait = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      core_wait = ($urandom_range(0, 7) == 0);
      if_req    = $urandom_range(0, 1) == 1;
      ihit      = ($urandom_range(0, 3) != 0);
      iready    = ($urandom_range(0, 2) == 0);
      mem_req   = $urandom_range(0, 1) == 1;
      dhit      = ($urandom_range(0, 3) != 0);
      dready    = ($urandom_range(0, 2) == 0);
      stall_req = N'($urandom & $urandom & $urandom);
      redir_req = N'($urandom & $urandom);
      for (int s = 0; s < N; s++) redir_pc[s*XL +: XL] = $urandom;
      #1;
      model(es, ef, ev, epc, im, dm);
      check_outs($sformatf("rnd%0d", c), es, ef, ev, epc);
      next_cycle();
      m_iwait = rst_n && im;
      m_dwait = rst_n && dm;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Parametrised pipeline flow controller: the successor to the fixed 5-stage flush/stall/jump unit. It generalises the stage count and the redirect sources, and tracks I-side and D-side cache misses with explicit per-port state machines rather than combinational latches. It resolves stall/flush/redirect priority across all stages and drives per-stage stall and flush vectors plus a one-cycle fetch redirect. It sits beside the pipeline registers and the bus controller in the core.

## Interface
- NSTAGE, 5, pipeline stage count; stage 0 = IF, stage NSTAGE-1 = WB; legal range 3..8
- XLEN, 32, PC width
- DSTAGE, 3, index of the stage that issues D-cache requests (MEM)
- CNTW, 32, perf counter width (only with PIPE_FLOW_CTRL_PERF_EN)
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- stall_req_i  in  NSTAGE  per-stage local stall request, e.g. load-use at ID
- redir_req_i  in  NSTAGE  per-stage redirect request (jump at ID, branch at EX); bit 0 is ignored
- redir_pc_i  in  NSTAGE*XLEN  redirect targets; slice k belongs to stage k
- if_req_i / icache_hit_i / icache_ready_i  in  1 each  I-side request, same-cycle hit, refill done
- mem_req_i / dcache_hit_i / dcache_ready_i  in  1 each  D-side request, same-cycle hit, refill done
- core_wait_i  in  1  bus wait; freezes the whole core
- stall_o  out  NSTAGE  stage k holds its input register
- flush_o  out  NSTAGE  stage k's input register loads a bubble; bit 0 flushes the fetch buffer
- redir_valid_o  out  1  one-cycle pulse that loads the PC
- redir_pc_o  out  XLEN  target qualified by redir_valid_o; 0 otherwise
- perf_stall_cnt_o / perf_redir_cnt_o  out  CNTW each  only with PIPE_FLOW_CTRL_PERF_EN

## Operation
- Miss tracker (one per port), states IDLE and WAIT:
  - IDLE -> WAIT when req & !hit.
  - WAIT -> IDLE on ready.
  - miss = (IDLE & req & !hit) | (WAIT & !ready).
  - The stall is therefore asserted combinationally in the miss cycle and drops in the ready cycle.
  - A req & hit in IDLE never stalls.
- Global stall G = core_wait_i | imiss | dmiss. When G is set:
  - stall_o = all ones, flush_o = 0, redir_valid_o = 0.
  - Redirects are not accepted. The requesting stage is frozen, so its request simply persists.
- Local stall, when !G: let j be the highest index with stall_req_i set.
  - stall_o[0..j] = 1.
  - flush_o[j+1] = 1 if j+1 < NSTAGE; this inserts a bubble behind the held stages.
- Redirect, when !G: let k be the highest index >= 1 with redir_req_i set. The oldest request wins.
  - The redirect is accepted only if no stall_req_i bit at index >= k is set.
  - On acceptance: redir_valid_o = 1 and redir_pc_o = slice k.
  - flush_o[0..k] = 1, and stall_o[0..k] is forced to 0. Flush beats stall for those stages.
  - A younger redirect or stall (index < k) in the same cycle is discarded.
  - If the redirect is not accepted, no redirect action is taken and the request must stay asserted.
- Requesters must hold redir_req_i until they are accepted. Acceptance flushes stage k's input, so the request cannot repeat in the next cycle. Edge detection is not used.
- dmiss freezes every stage, including stages after DSTAGE. No partial retire is performed.

## Timing
- All stall, flush and redirect outputs are combinational from the inputs and the tracker state. There is zero-cycle latency from request to control.
- Tracker state updates on posedge clk.
- Reset (rst_n = 0 at an edge):
  - Both trackers go to IDLE and the counters clear.
  - While rst_n = 0: stall_o = 0, flush_o = all ones, redir_valid_o = 0, redir_pc_o = 0.
- Reset asserted while a tracker is in WAIT: the tracker returns to IDLE and a late ready is ignored.
- ready and a new req & !hit on the same port in the same cycle: the tracker stays in WAIT and miss stays 1.
- imiss and dmiss together: both trackers are serviced independently. G holds until both have cleared.

## Configuration
- PIPE_FLOW_CTRL_PERF_EN defined: the two CNTW-bit saturating counters are built and the perf ports exist.
  - perf_stall_cnt_o counts cycles with G | (any stall_req_i).
  - perf_redir_cnt_o counts redir_valid_o pulses.
- PIPE_FLOW_CTRL_PERF_EN undefined: the counters and perf ports are absent. Control behaviour is identical.

## Structure
- Package pipe_flow_pkg holds:
  - the tracker state enum (TRK_IDLE, TRK_WAIT);
  - the default stage index constants (STG_IF = 0, STG_ID = 1, STG_EX = 2, STG_MEM = 3, STG_WB = 4).
- Sub-module miss_tracker holds the IDLE/WAIT FSM. It is instantiated twice, once for the I-side and once for the D-side.

## Test plan
- if_req_i = 1, icache_hit_i = 0 at cycle 0; icache_ready_i = 1 at cycle 4 -> stall_o = 5'b11111 for cycles 0..3, 0 at cycle 4, flush_o = 0 throughout.
- stall_req_i = 5'b00010 (load-use at ID) -> stall_o = 5'b00011, flush_o = 5'b00100.
- redir_req_i = 5'b00110 with ID target 0x100 and EX target 0x200 -> redir_valid_o = 1, redir_pc_o = 0x200, flush_o = 5'b00111, stall_o = 0.
- redir_req_i[2] = 1 (target 0x80) with core_wait_i = 1 for 3 cycles -> no redirect for 3 cycles, then a single pulse with redir_pc_o = 0x80.
- stall_req_i[3] = 1 with redir_req_i[1] = 1 -> redirect not accepted, stall_o = 5'b01111, flush_o = 5'b10000.
- D-miss in WAIT, then rst_n = 0 for 1 cycle, then dcache_ready_i = 1 -> tracker IDLE, no stall after reset; with PIPE_FLOW_CTRL_PERF_EN defined, the counters read 0.
